// File: rtl/rom_arbiter.sv
// Round-robin arbiter giving instruction fetch (A) and data load (B) shared access to one code ROM.
// A tag pipeline follows each read so the returned word reaches the port that issued it.
module rom_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_req,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  rom_rd_ena,
  output logic [ADDR_WIDTH-1:0] rom_address,
  input  logic [DATA_WIDTH-1:0] rom_data
);

  // last_gnt_q = 1 means B was granted most recently, so A wins the next tie
  logic                  last_gnt_q, last_gnt_d;
  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic [RD_LATENCY-1:0] sel_q, sel_d;
  logic                  pick_a, pick_b;

  always_comb begin
    pick_a      = a_req & (~b_req | last_gnt_q);
    pick_b      = b_req & (~a_req | ~last_gnt_q);
    a_gnt       = pick_a & rst_n;
    b_gnt       = pick_b & rst_n;
    rom_rd_ena  = a_gnt | b_gnt;
    rom_address = '0;
    if (a_gnt) begin
      rom_address = a_addr;
    end else if (b_gnt) begin
      rom_address = b_addr;
    end

    last_gnt_d = last_gnt_q;
    if (a_gnt) begin
      last_gnt_d = 1'b0;
    end else if (b_gnt) begin
      last_gnt_d = 1'b1;
    end

    vld_d    = '0;
    sel_d    = '0;
    vld_d[0] = rom_rd_ena;
    sel_d[0] = b_gnt;
    for (int i = 1; i < RD_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      sel_d[i] = sel_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q <= 1'b1;
      vld_q      <= '0;
      sel_q      <= '0;
    end else begin
      last_gnt_q <= last_gnt_d;
      vld_q      <= vld_d;
      sel_q      <= sel_d;
    end
  end

  // The last tag stage lines up with the ROM's registered output for that read
  always_comb begin
    a_rvalid = vld_q[RD_LATENCY-1] & ~sel_q[RD_LATENCY-1];
    b_rvalid = vld_q[RD_LATENCY-1] &  sel_q[RD_LATENCY-1];
    a_rdata  = a_rvalid ? rom_data : '0;
    b_rdata  = b_rvalid ? rom_data : '0;
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: a latency-1 and a latency-3 instance share stimulus,
// each backed by a ROM model returning 32'hC000_0000 | address.
module tb_rom_arbiter;

  logic        clk;
  logic        rst_n;
  logic        a_req, b_req;
  logic [31:0] a_addr, b_addr;

  logic        a_gnt1, b_gnt1, a_rv1, b_rv1, ena1;
  logic [31:0] a_rd1, b_rd1, addr1, data1;
  logic        a_gnt3, b_gnt3, a_rv3, b_rv3, ena3;
  logic [31:0] a_rd3, b_rd3, addr3;
  logic [31:0] m3 [3];

  int total;
  int bad;

  rom_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RD_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_addr(a_addr), .a_gnt(a_gnt1), .a_rvalid(a_rv1), .a_rdata(a_rd1),
    .b_req(b_req), .b_addr(b_addr), .b_gnt(b_gnt1), .b_rvalid(b_rv1), .b_rdata(b_rd1),
    .rom_rd_ena(ena1), .rom_address(addr1), .rom_data(data1)
  );

  rom_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RD_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_addr(a_addr), .a_gnt(a_gnt3), .a_rvalid(a_rv3), .a_rdata(a_rd3),
    .b_req(b_req), .b_addr(b_addr), .b_gnt(b_gnt3), .b_rvalid(b_rv3), .b_rdata(b_rd3),
    .rom_rd_ena(ena3), .rom_address(addr3), .rom_data(m3[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ROM models: synchronous reset, read-enable gated, registered output
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data1 <= '0;
      m3[0] <= '0;
      m3[1] <= '0;
      m3[2] <= '0;
    end else begin
      if (ena1) data1 <= 32'hC000_0000 | addr1;
      if (ena3) m3[0] <= 32'hC000_0000 | addr3;
      m3[1] <= m3[0];
      m3[2] <= m3[1];
    end
  end

  typedef struct {
    logic        a_req;
    logic [31:0] a_addr;
    logic        b_req;
    logic [31:0] b_addr;
    logic        e_a_gnt;
    logic        e_b_gnt;
    logic [31:0] e_rom_addr;
    logic        e_a_rv;
    logic [31:0] e_a_rd;
    logic        e_b_rv;
    logic [31:0] e_b_rd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic ar, input logic [31:0] aa, input logic br, input logic [31:0] ba,
                              input logic ag, input logic bg, input logic [31:0] ra,
                              input logic arv, input logic [31:0] ard, input logic brv, input logic [31:0] brd);
    vec_t v;
    v.a_req = ar; v.a_addr = aa; v.b_req = br; v.b_addr = ba;
    v.e_a_gnt = ag; v.e_b_gnt = bg; v.e_rom_addr = ra;
    v.e_a_rv = arv; v.e_a_rd = ard; v.e_b_rv = brv; v.e_b_rd = brd;
    return v;
  endfunction

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic ar, input logic [31:0] aa, input logic br, input logic [31:0] ba);
    @(posedge clk);
    #1;
    a_req = ar; a_addr = aa; b_req = br; b_addr = ba;
  endtask

  task automatic checkOutput(input string tag, input vec_t v);
    @(negedge clk);
    checkValue({tag, " a_gnt"}, 32'(a_gnt1), 32'(v.e_a_gnt));
    checkValue({tag, " b_gnt"}, 32'(b_gnt1), 32'(v.e_b_gnt));
    checkValue({tag, " rd_ena"}, 32'(ena1), 32'(v.e_a_gnt | v.e_b_gnt));
    checkValue({tag, " rom_address"}, addr1, v.e_rom_addr);
    checkValue({tag, " a_rvalid"}, 32'(a_rv1), 32'(v.e_a_rv));
    checkValue({tag, " a_rdata"}, a_rd1, v.e_a_rd);
    checkValue({tag, " b_rvalid"}, 32'(b_rv1), 32'(v.e_b_rv));
    checkValue({tag, " b_rdata"}, b_rd1, v.e_b_rd);
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // Alternating tie: grants A,B,A,B with responses one cycle later
    vecs.push_back(mk(1, 32'h4, 1, 32'h8, 1, 0, 32'h4, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h4, 1, 32'h8, 0, 1, 32'h8, 1, 32'hC000_0004, 0, 0));
    vecs.push_back(mk(1, 32'h4, 1, 32'h8, 1, 0, 32'h4, 0, 0, 1, 32'hC000_0008));
    vecs.push_back(mk(1, 32'h4, 1, 32'h8, 0, 1, 32'h8, 1, 32'hC000_0004, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hC000_0008));
    // Single A read
    vecs.push_back(mk(1, 32'h10, 0, 0, 1, 0, 32'h10, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'hC000_0010, 0, 0));
    // Back-to-back A reads 0..7
    for (int i = 0; i < 8; i++) begin
      vecs.push_back(mk(1, 32'(i), 0, 0, 1, 0, 32'(i), (i > 0), (i > 0) ? (32'hC000_0000 | 32'(i - 1)) : 32'h0, 0, 0));
    end
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'hC000_0007, 0, 0));

    // Reset state, with A requesting to show grants are masked
    rst_n = 1'b0;
    a_req = 1'b1; a_addr = 32'h5; b_req = 1'b1; b_addr = 32'h6;
    @(posedge clk);
    @(negedge clk);
    checkValue("reset a_gnt", 32'(a_gnt1), 0);
    checkValue("reset b_gnt", 32'(b_gnt1), 0);
    checkValue("reset rd_ena", 32'(ena1), 0);
    checkValue("reset rom_address", addr1, 0);
    checkValue("reset a_rvalid", 32'(a_rv1), 0);
    checkValue("reset b_rvalid", 32'(b_rv1), 0);
    checkValue("reset a_rdata", a_rd1, 0);
    checkValue("reset b_rdata", b_rd1, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    a_req = 1'b0; b_req = 1'b0; a_addr = '0; b_addr = '0;

    foreach (vecs[k]) begin
      applyStimulus(vecs[k].a_req, vecs[k].a_addr, vecs[k].b_req, vecs[k].b_addr);
      checkOutput($sformatf("vec%0d", k), vecs[k]);
    end

    // Drain the latency-3 instance
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);

    // Latency 3: B read of 0x20 answers exactly three cycles after the grant
    applyStimulus(0, 0, 1, 32'h20);
    @(negedge clk);
    checkValue("lat3 b_gnt", 32'(b_gnt3), 1);
    checkValue("lat3 rom_address", addr3, 32'h20);
    checkValue("lat3 b_rvalid c0", 32'(b_rv3), 0);
    for (int c = 1; c <= 4; c++) begin
      applyStimulus(0, 0, 0, 0);
      @(negedge clk);
      checkValue($sformatf("lat3 b_rvalid c%0d", c), 32'(b_rv3), (c == 3) ? 1 : 0);
      checkValue($sformatf("lat3 b_rdata c%0d", c), b_rd3, (c == 3) ? 32'hC000_0020 : 0);
      checkValue($sformatf("lat3 a_rvalid c%0d", c), 32'(a_rv3), 0);
      if (c == 1) begin
        checkValue("lat1 b_rvalid", 32'(b_rv1), 1);
        checkValue("lat1 b_rdata", b_rd1, 32'hC000_0020);
      end
    end

    // B requests then drops while A wins the tie; pointer must stay on A
    applyStimulus(1, 32'h30, 1, 32'h31);
    checkOutput("drop c0", mk(1, 32'h30, 1, 32'h31, 1, 0, 32'h30, 0, 0, 0, 0));
    applyStimulus(0, 0, 0, 0);
    checkOutput("drop c1", mk(0, 0, 0, 0, 0, 0, 0, 1, 32'hC000_0030, 0, 0));
    applyStimulus(1, 32'h32, 1, 32'h33);
    checkOutput("drop c2", mk(1, 32'h32, 1, 32'h33, 0, 1, 32'h33, 0, 0, 0, 0));
    applyStimulus(0, 0, 0, 0);
    checkOutput("drop c3", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hC000_0033));

    // Reset one cycle after an A grant discards the in-flight read
    applyStimulus(1, 32'h40, 0, 0);
    @(negedge clk);
    checkValue("rstmid a_gnt", 32'(a_gnt1), 1);
    applyStimulus(0, 0, 0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    checkValue("rstmid a_rvalid lat1", 32'(a_rv1), 0);
    checkValue("rstmid a_rdata lat1", a_rd1, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkValue($sformatf("rstmid a_rvalid1 c%0d", c), 32'(a_rv1), 0);
      checkValue($sformatf("rstmid a_rvalid3 c%0d", c), 32'(a_rv3), 0);
      @(posedge clk);
    end
    #1;
    a_req = 1'b1; a_addr = 32'h50; b_req = 1'b1; b_addr = 32'h51;
    @(negedge clk);
    checkValue("post-reset tie a_gnt", 32'(a_gnt1), 1);
    checkValue("post-reset tie b_gnt", 32'(b_gnt1), 0);
    checkValue("post-reset tie a_gnt lat3", 32'(a_gnt3), 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("post-reset resp", mk(0, 0, 0, 0, 0, 0, 0, 1, 32'hC000_0050, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
